shift_reg_serializer: RTL and testbench

//  - Parallel-to-serial output stage; sits downstream of the clock divider.
//  - Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB-first.
//  - Runs on the same div[3:0] rate setting as the divider, but stays on a single

---
 rtl/shift_reg_serializer.sv | 156 +++++++++++++++
 tb/tb_shift_reg_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_serializer.sv
// Parallel-to-serial output stage: MSB-first sdata with a self-generated sclk on clk_in.
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module shift_reg_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [3:0]       div,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned TICK_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [3:0]         div_q, div_d;
  logic               sdata_q, sdata_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SER_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               accept;
  logic               period_end;
  logic [TICK_W-1:0]  tick_last;

  assign load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept     = load_valid && load_ready;
  assign tick_last  = TICK_W'({div_q, 1'b0}) - TICK_W'(1);
  assign period_end = (tick_q == tick_last);

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    div_d   = div_q;
    sdata_d = 1'b0;
    sclk_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_SHIFT;
          shift_d = load_data;
          div_d   = (div == 4'd0) ? 4'd1 : div;
          cnt_d   = CNT_W'(WIDTH - 1);
          tick_d  = '0;
`ifdef SER_PARITY_EN
          par_d   = ^load_data;
`endif
        end
      end
      S_SHIFT: begin
        if (period_end) begin
          tick_d  = '0;
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
`ifdef SER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (period_end) begin
          tick_d  = '0;
          state_d = S_DONE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT) || (state_d == S_PARITY);
    done_d = (state_d == S_DONE);
    sclk_d = busy_d && (tick_d >= TICK_W'(div_d));
    case (state_d)
      S_SHIFT:  sdata_d = shift_d[WIDTH-1];
`ifdef SER_PARITY_EN
      S_PARITY: sdata_d = par_q;
`endif
      S_DONE:   sdata_d = sdata_q;
      default:  sdata_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
      div_q   <= '0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sdata = sdata_q;
  assign sclk  = sclk_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_shift_reg_serializer.sv
// Randomized self-checking bench for shift_reg_serializer against a cycle-indexed waveform model.
module tb_shift_reg_serializer;

  localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic         clk_in = 1'b0;
  logic         rst;
  logic [3:0]   div;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready, sdata, sclk, busy, done;
  logic [4:0]   got;

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_serializer #(.WIDTH(W)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div        (div),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sdata      (sdata),
    .sclk       (sclk),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  assign got = {sdata, sclk, busy, done, load_ready};

  function automatic int eff_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Expected {sdata,sclk,busy,done,load_ready} for cycle k after the accept edge (k=1 is the first).
  function automatic logic [4:0] exp_at(input logic [W-1:0] data, input int d, input int k);
    int   per;
    int   idx;
    logic b;
    logic last;
    per  = 2 * d;
    last = (NB > W) ? ^data : data[0];
    if (k >= 1 && k <= int'(NB) * per) begin
      idx = (k - 1) / per;
      b   = (idx < int'(W)) ? data[int'(W) - 1 - idx] : ^data;
      return {b, ((k - 1) % per) >= d, 1'b1, 1'b0, 1'b0};
    end else if (k == int'(NB) * per + 1) begin
      return {last, 1'b0, 1'b0, 1'b1, 1'b1};
    end
    return 5'b00001;
  endfunction

  task automatic test_reset();
    rst = 1'b0; div = 4'd0; load_data = '0; load_valid = 1'b0;
    #1;
    n_cmp++;
    if (got !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_async: got %b expected %b", got, 5'b00001);
    end
    @(negedge clk_in);
    rst = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if (got !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected %b", got, 5'b00001);
    end
  endtask

  // Directed vectors followed by random words and rates, each frame checked cycle by cycle.
  task automatic test_frames();
    logic [W-1:0] dq[$];
    int           vq[$];
    int           d, n;
    logic [4:0]   e;
    dq = '{8'hA5, 8'h81, 8'h3C, 8'h07};
    vq = '{1, 4, 0, 1};
    for (int i = 0; i < 12; i++) begin
      dq.push_back(W'($urandom));
      vq.push_back(int'($urandom_range(0, 15)));
    end
    foreach (dq[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      load_data  = dq[i];
      div        = 4'(vq[i]);
      load_valid = 1'b1;
      d = eff_div(vq[i]);
      n = int'(NB) * 2 * d;
      @(negedge clk_in);
      load_valid = 1'b0;
      for (int k = 1; k <= n + 2; k++) begin
        if (k > 1) @(negedge clk_in);
        e = exp_at(dq[i], d, k);
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL frame data=%h div=%0d cycle=%0d: got %b expected %b", dq[i], vq[i], k, got, e);
        end
      end
    end
  endtask

  task automatic test_div_change();
    logic [4:0] e;
    load_data  = 8'h5A;
    div        = 4'd1;
    load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0;
    div        = 4'd8;
    for (int k = 1; k <= int'(NB) * 2 + 2; k++) begin
      if (k > 1) @(negedge clk_in);
      e = exp_at(8'h5A, 1, k);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL div_change cycle=%0d: got %b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int         n;
    n = int'(NB) * 2 * 2;
    div        = 4'd2;
    load_data  = 8'h12;
    load_valid = 1'b1;
    @(negedge clk_in);
    load_data = 8'h34;
    for (int k = 1; k <= n + 1; k++) begin
      if (k > 1) @(negedge clk_in);
      e = exp_at(8'h12, 2, k);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL b2b_first cycle=%0d: got %b expected %b", k, got, e);
      end
    end
    @(negedge clk_in);
    load_valid = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      if (k > 1) @(negedge clk_in);
      e = exp_at(8'h34, 2, k);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL b2b_second cycle=%0d: got %b expected %b", k, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] e;
    div        = 4'd2;
    load_data  = 8'hA5;
    load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) @(negedge clk_in);
      e = exp_at(8'hA5, 2, k);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL rst_mid_pre cycle=%0d: got %b expected %b", k, got, e);
      end
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (got !== 5'b00001) begin
      n_err++;
      $display("FAIL rst_mid_immediate: got %b expected %b", got, 5'b00001);
    end
    @(negedge clk_in);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (got !== 5'b00001) begin
        n_err++;
        $display("FAIL rst_mid_no_done cycle=%0d: got %b expected %b", k, got, 5'b00001);
      end
    end
    div        = 4'd1;
    load_data  = 8'hFF;
    load_valid = 1'b1;
    @(negedge clk_in);
    load_valid = 1'b0;
    for (int k = 1; k <= int'(NB) * 2 + 2; k++) begin
      if (k > 1) @(negedge clk_in);
      e = exp_at(8'hFF, 1, k);
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL rst_mid_fresh cycle=%0d: got %b expected %b", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_div_change();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
